// File: rtl/vga_fb_scanout.sv
// Raster-order reader for the 160x120x3 framebuffer: each stored pixel is repeated
// 4x4 onto a 640x480@60 VGA frame, with sync/blank timing and a per-frame tick.
module vga_fb_scanout #(
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SW        = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SW        = 2,
  parameter int V_BP        = 33,
  parameter int FB_W        = 160,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [2:0]        fb_data,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic [9:0]        VGA_R,
  output logic [9:0]        VGA_G,
  output logic [9:0]        VGA_B,
  output logic              frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_L  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG_L = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END_L = HW'(H_VIS + H_FP + H_SW);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG_L = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END_L = VW'(V_VIS + V_FP + V_SW);

  logic              phase_q;
  logic [HW-1:0]     h_q;
  logic [VW-1:0]     v_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic              fb_rd_q;
  logic              hs_dly_q, vs_dly_q, vis_dly_q, first_dly_q;
  logic              hs_q, vs_q, blank_n_q, frame_start_q;
  logic [2:0]        rgb_q;

  logic              vis_d, hs_d, vs_d, first_d;
  logic [ADDR_W-1:0] x_ext, y_ext, addr_d;

  assign vis_d   = (h_q < H_VIS_L) && (v_q < V_VIS_L);
  assign hs_d    = !((h_q >= HS_BEG_L) && (h_q < HS_END_L));
  assign vs_d    = !((v_q >= VS_BEG_L) && (v_q < VS_END_L));
  assign first_d = (h_q == '0) && (v_q == '0);

  assign x_ext = ADDR_W'(h_q >> SCALE_SHIFT);
  assign y_ext = ADDR_W'(v_q >> SCALE_SHIFT);

  // A 160-pixel row stride is 128+32, so the row offset needs no multiplier.
  generate
    if (FB_W == 160) begin : gen_stride_shift
      assign addr_d = (y_ext << 7) + (y_ext << 5) + x_ext;
    end else begin : gen_stride_mul
      localparam logic [ADDR_W-1:0] FB_W_L = ADDR_W'(FB_W);
      assign addr_d = y_ext * FB_W_L + x_ext;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase_q       <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      fb_addr_q     <= '0;
      fb_rd_q       <= 1'b0;
      hs_dly_q      <= 1'b1;
      vs_dly_q      <= 1'b1;
      vis_dly_q     <= 1'b0;
      first_dly_q   <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= 3'b000;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= ~phase_q;
      frame_start_q <= 1'b0;
      if (phase_q) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
        // Stage 1: issue the read and delay the flags to line up with fb_data.
        fb_rd_q <= vis_d;
        if (vis_d) fb_addr_q <= addr_d;
        hs_dly_q    <= hs_d;
        vs_dly_q    <= vs_d;
        vis_dly_q   <= vis_d;
        first_dly_q <= first_d;
        // Stage 2: every pin updates together from the delayed flags.
        hs_q          <= hs_dly_q;
        vs_q          <= vs_dly_q;
        blank_n_q     <= vis_dly_q;
        rgb_q         <= vis_dly_q ? fb_data : 3'b000;
        frame_start_q <= first_dly_q;
      end
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_rd       = fb_rd_q;
  assign VGA_CLK     = phase_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = {10{rgb_q[2]}};
  assign VGA_G       = {10{rgb_q[1]}};
  assign VGA_B       = {10{rgb_q[0]}};
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: closed-form model indexed by clk edges since reset release,
// plus directed literal checks on timing, addressing, data alignment and blanking.
module tb_vga_fb_scanout;

  localparam int HV  = 640;
  localparam int HT  = 800;
  localparam int HSB = 656;
  localparam int HSE = 752;
  localparam int VV  = 10;
  localparam int VSB = 11;
  localparam int VSE = 13;
  localparam int VT  = 14;
  localparam int TOT = HT * VT;
  localparam int FRAME_CLK = 2 * TOT;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        force_ones = 1'b0;
  logic        chk_en = 1'b0;
  logic [14:0] fb_addr;
  logic        fb_rd;
  logic [2:0]  ram_q = 3'b000;
  logic [2:0]  fb_data;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [9:0]  VGA_R, VGA_G, VGA_B;

  int n_checks = 0;
  int n_pass   = 0;
  int m = 0;

  always #10 clk = ~clk;

  vga_fb_scanout #(
    .V_VIS(VV), .V_FP(1), .V_SW(2), .V_BP(1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start)
  );

  // Framebuffer contents: addr0=3'b101, addr1=3'b010, ...
  function automatic logic [2:0] pat(int a);
    int t;
    t = a * 5 + 5;
    return t[2:0];
  endfunction

  function automatic int addr_of(int h, int v);
    return (v / 4) * 160 + h / 4;
  endfunction

  always @(posedge clk) ram_q <= pat(int'(fb_addr));
  assign fb_data = force_ones ? 3'b111 : ram_q;

  always @(posedge clk) begin
    if (!resetn) m <= 0;
    else         m <= m + 1;
  end

  // Expected pin state after the mm-th edge following reset release.
  function automatic logic [51:0] model(int mm, bit frc);
    logic rd, ck, hs, vs, bl, fs;
    logic [14:0] ad;
    logic [2:0] c;
    int p, h, v;
    rd = 1'b0; ad = '0; ck = mm[0]; hs = 1'b1; vs = 1'b1; bl = 1'b0; c = 3'b000; fs = 1'b0;
    if (mm >= 2) begin
      p = (mm / 2 - 1) % TOT;
      h = p % HT;
      v = p / HT;
      rd = (h < HV) && (v < VV);
      if (rd)          ad = 15'(addr_of(h, v));
      else if (v < VV) ad = 15'(addr_of(HV - 1, v));
      else             ad = 15'(addr_of(HV - 1, VV - 1));
    end
    if (mm >= 4) begin
      p = (mm / 2 - 2) % TOT;
      h = p % HT;
      v = p / HT;
      hs = !(h >= HSB && h < HSE);
      vs = !(v >= VSB && v < VSE);
      bl = (h < HV) && (v < VV);
      if (bl) c = frc ? 3'b111 : pat(addr_of(h, v));
      fs = (mm % 2 == 0) && (p == 0);
    end
    return {rd, ad, ck, hs, vs, bl, 1'b1, {10{c[2]}}, {10{c[1]}}, {10{c[0]}}, fs};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s at m=%0d: got %h, required %h", name, m, got, want);
  endtask

  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {12'h0, fb_rd, fb_addr, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
                      VGA_R, VGA_G, VGA_B, frame_start}, {12'h0, model(m, force_ones)});
  end

  int blank_line, blank_frame, vs_low, fs_first, fs_second;
  always @(negedge clk) begin
    if (m == 0) begin
      blank_line <= 0; blank_frame <= 0; vs_low <= 0; fs_first <= -1; fs_second <= -1;
    end else begin
      if (m >= 4 && m < 4 + 2 * HT) blank_line <= blank_line + int'(VGA_BLANK_N);
      if (m >= 4 && m < 4 + FRAME_CLK) begin
        blank_frame <= blank_frame + int'(VGA_BLANK_N);
        vs_low      <= vs_low + int'(!VGA_VS);
      end
      if (frame_start) begin
        if (fs_first < 0)       fs_first  <= m;
        else if (fs_second < 0) fs_second <= m;
      end
    end
  end

  task automatic wait_m(int target);
    int g;
    g = 0;
    while (m < target && g < 60000) begin
      @(negedge clk);
      g++;
    end
    if (m != target) check("wait_bound", m, target);
  endtask

  initial begin
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_blank_n", VGA_BLANK_N, 1'b0);
    check("rst_hs", VGA_HS, 1'b1);
    check("rst_vs", VGA_VS, 1'b1);
    check("rst_fs", frame_start, 1'b0);
    resetn = 1'b1;

    wait_m(4);
    check("fs_first_pulse", frame_start, 1'b1);
    check("px0_r", VGA_R, 10'h3FF);
    check("px0_g", VGA_G, 10'h000);
    check("px0_b", VGA_B, 10'h3FF);
    wait_m(5);
    check("fs_cleared", frame_start, 1'b0);
    wait_m(11);
    check("px3_r", VGA_R, 10'h3FF);
    wait_m(12);
    check("px4_r", VGA_R, 10'h000);
    check("px4_g", VGA_G, 10'h3FF);
    check("px4_b", VGA_B, 10'h000);
    wait_m(19);
    check("px7_g", VGA_G, 10'h3FF);
    wait_m(1282);
    check("addr_640_0_rd", fb_rd, 1'b0);
    check("addr_640_0_hold", fb_addr, 15'd159);
    wait_m(1315);
    check("hs_before_fall", VGA_HS, 1'b1);
    wait_m(1316);
    check("hs_fall", VGA_HS, 1'b0);
    wait_m(1507);
    check("hs_low_end", VGA_HS, 1'b0);
    wait_m(1508);
    check("hs_rise", VGA_HS, 1'b1);
    wait_m(1605);
    check("blank_per_line", blank_line, 1280);
    wait_m(2915);
    check("hs_before_fall2", VGA_HS, 1'b1);
    wait_m(2916);
    check("hs_fall2", VGA_HS, 1'b0);
    wait_m(14412);
    check("addr_5_9", fb_addr, 15'd321);
    check("addr_5_9_rd", fb_rd, 1'b1);

    // Pulse reset mid-frame at (300,9) and run on with fb_data stuck at 3'b111.
    wait_m(15002);
    resetn = 1'b0;
    force_ones = 1'b1;
    @(negedge clk);
    check("midrst_blank_n", VGA_BLANK_N, 1'b0);
    check("midrst_vga_clk", VGA_CLK, 1'b0);
    check("midrst_fb_rd", fb_rd, 1'b0);
    check("midrst_r", VGA_R, 10'h000);
    resetn = 1'b1;

    wait_m(4);
    check("fs_after_midrst", frame_start, 1'b1);
    check("forced_vis_r", VGA_R, 10'h3FF);
    check("forced_vis_b", VGA_B, 10'h3FF);
    wait_m(1284);
    check("forced_hblank_r", VGA_R, 10'h000);
    check("forced_hblank_g", VGA_G, 10'h000);
    check("forced_hblank_b", VGA_B, 10'h000);
    wait_m(4 + FRAME_CLK + 1);
    check("fs_first_at", fs_first, 4);
    check("fs_period", fs_second - fs_first, FRAME_CLK);
    check("vs_low_per_frame", vs_low, 3200);
    check("blank_per_frame", blank_frame, 12800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
Reader end of the 160x120x3-bit framebuffer that the game's display logic writes through (x, y, colour, plot). It continuously fetches pixels in raster order, upscales each one 4x4 to 640x480@60 Hz, and drives the board VGA DAC pins plus hsync, vsync and blanking. It also emits a once-per-frame pulse that the game datapath can use as a tick.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SW, 96, hsync width in pixels
H_BP, 48, horizontal back porch in pixels
V_VIS, 480, visible lines
V_FP, 10, vertical front porch in lines
V_SW, 2, vsync width in lines
V_BP, 33, vertical back porch in lines
FB_W, 160, framebuffer width; FB_W<<SCALE_SHIFT must equal H_VIS
SCALE_SHIFT, 2, log2 of the upscale factor
ADDR_W, 15, framebuffer address width

Ports:
clk  in  1  50 MHz system clock
resetn  in  1  synchronous active-low reset
fb_addr  out  ADDR_W  framebuffer read address
fb_rd  out  1  read enable, high only for visible pixels
fb_data  in  3  colour at fb_addr ({R,G,B}), valid 1 clk after fb_addr/fb_rd are registered
VGA_CLK  out  1  pixel clock (25 MHz)
VGA_HS  out  1  hsync, active low
VGA_VS  out  1  vsync, active low
VGA_BLANK_N  out  1  high during visible region
VGA_SYNC_N  out  1  constant 1
VGA_R, VGA_G, VGA_B  out  10 each  colour channel
frame_start  out  1  1-clk pulse coincident with output of pixel (0,0)

Behaviour:
- Reset: clk and resetn are synchronous, active-low as stated in Ports. While resetn=0 at a clk edge:
  - phase=0, h_cnt=0, v_cnt=0.
  - fb_addr=0, fb_rd=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_SYNC_N=1, R/G/B=0, frame_start=0, VGA_CLK=0.
  - The first edge with resetn=1 takes the normal path.
- Pixel tick:
  - phase toggles every clk; VGA_CLK = phase.
  - A tick is any clk edge where phase==1 before the edge, so ticks fall on every second edge and the first tick is the 2nd edge after reset release.
- Counters, updated on ticks only:
  - h_cnt runs 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SW+H_BP = 800.
  - At the wrap, h_cnt returns to 0 and v_cnt increments over 0..V_TOT-1 (V_TOT = 525), wrapping to 0.
- Stage 1, on a tick, from the pre-increment (h,v):
  - fb_rd <= (h<H_VIS && v<V_VIS).
  - fb_addr <= (v>>2)*FB_W + (h>>2) when visible, otherwise hold.
  - Compute the multiply as (y<<7)+(y<<5)+x. Maximum address is 19199.
  - Latch the timing flags for (h,v) into a 1-deep delay register:
    - hs_n = !(H_VIS+H_FP <= h < H_VIS+H_FP+H_SW)
    - vs_n = !(V_VIS+V_FP <= v < V_VIS+V_FP+V_SW)
    - vis = fb_rd condition
    - first = (h==0 && v==0)
- Stage 2, on the next tick, all outputs update from the delayed flags together:
  - VGA_HS <= hs_n, VGA_VS <= vs_n, VGA_BLANK_N <= vis.
  - Each channel becomes 10'h3FF if its fb_data bit (R=[2], G=[1], B=[0]) is 1 and vis, else 0.
  - frame_start <= first, and is cleared on the following clk (1-clk pulse).
- Latency: pixel (h,v) appears on the outputs exactly 1 tick (2 clk) after its address is registered, and 4 clk edges after the counter reaches it from reset.
- Blanking: colour is forced to 0 whenever vis=0, regardless of fb_data.
- Output timing: outputs change only on tick edges, so VGA_CLK rises mid-pixel.
- Reset mid-frame: everything restarts at (0,0), the pipeline flushes to reset values, and no partial pixel is emitted.
- fb_data outside the cycle after a visible read is ignored.

Test Plan:
- Reset timing: resetn=0 for 5 clk, then 1 -> all outputs hold reset values during reset; first tick at edge 2 after release; frame_start=1 exactly after edge 4, for 1 clk.
- Horizontal timing: run 2 lines -> VGA_HS period 1600 clk; HS low for 192 clk, starting 2 clk after the tick that registers h=656; VGA_BLANK_N high 1280 clk per line.
- Vertical timing: run 2 frames -> frame_start period 840000 clk; VGA_VS low for 3200 clk per frame; VGA_BLANK_N never high on lines 480..524.
- Addressing: (h=5,v=9) -> fb_addr=321, fb_rd=1; (639,479) -> 19199; (640,0) -> fb_rd=0 with fb_addr held at 159.
- Data alignment with a 1-clk-latency RAM model (addr0=3'b101, addr1=3'b010):
  - Output pixels 0-3 of line 0 are R=3FF, G=0, B=3FF.
  - Output pixels 4-7 are R=0, G=3FF, B=0.
  - Pixels in h>=640 have R=G=B=0 even with fb_data=3'b111 forced.
- Mid-frame reset: resetn=0 for 1 clk at (h=300,v=200) -> outputs return to reset values next edge; frame_start recurs 4 clk after release; no HS/VS glitch shorter than spec widths.
